counter_ud_lim: RTL
===================

Name: counter_ud_lim

Overview:
- Parametrised successor to the team's 4-bit up/down loadable counter.
- Adds:
  - configurable width
  - programmable step size
  - runtime lower/upper limits
  - wrap or saturate mode at the limits
  - boundary-event pulse
  - sticky overflow/underflow flags
  - configuration-error detect
- Used as a general event/position counter in timer, PWM and address-sequencing blocks.

Parameters:
- WIDTH, 4, counter and limit width in bits.
- STEP_W, 2, width of step input; step range 0..2^STEP_W-1.
- RST_VAL, 0, count value after reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable.
- up  input  1  1 = count up, 0 = count down.
- load  input  1  parallel load request.
- data  input  WIDTH  load value.
- step  input  STEP_W  increment/decrement magnitude; 0 = hold.
- lo_lim  input  WIDTH  lower count limit (inclusive).
- hi_lim  input  WIDTH  upper count limit (inclusive).
- mode  input  1  0 = wrap, 1 = saturate.
- clr_flags  input  1  clears sticky flags.
- count  output  WIDTH  registered count.
- bnd_pulse  output  1  registered one-cycle pulse: limit crossed in previous update.
- ovf  output  1  sticky: upper limit crossed.
- unf  output  1  sticky: lower limit crossed.
- at_hi  output  1  combinational, count == hi_lim.
- at_lo  output  1  combinational, count == lo_lim.
- cfg_err  output  1  combinational, lo_lim > hi_lim.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: count = RST_VAL, bnd_pulse = 0, ovf = 0, unf = 0.
- Reset wins over all other inputs, including mid-operation.
- Priority per edge: rst > load > en. No effect when all are inactive: count holds and bnd_pulse = 0.
- Load:
  - count <= data clamped to [lo_lim, hi_lim]: data > hi_lim gives hi_lim; data < lo_lim gives lo_lim.
  - Load never sets bnd_pulse, ovf or unf.
- cfg_err = 1 (lo_lim > hi_lim):
  - load and count are both inhibited; count holds.
  - No flags are set.
- Count enabled (en = 1, load = 0, cfg_err = 0):
  - Arithmetic is done at WIDTH+1 bits, so there is no silent modular wrap.
  - count out of range (above hi_lim or below lo_lim, e.g. after a limit change): snap to the nearest limit in one cycle. No flags set.
  - step = 0: hold. No flags set.
  - Up, next = count + step:
    - next <= hi_lim: count <= next.
    - Otherwise it is an overflow event.
    - Wrap mode: count <= lo_lim. Saturate mode: count <= hi_lim.
    - On the event, ovf <= 1 and bnd_pulse <= 1. In saturate mode this repeats every enabled cycle while held at the limit.
  - Down, next = count - step, signed extended:
    - next >= lo_lim: count <= next.
    - Otherwise it is an underflow event.
    - Wrap mode: count <= hi_lim. Saturate mode: count <= lo_lim.
    - On the event, unf <= 1 and bnd_pulse <= 1.
  - Wrap goes to the opposite limit; excess step is discarded. Full range (lo = 0, hi = 2^WIDTH-1) behaves the same way.
- Flags:
  - clr_flags clears ovf and unf on the next edge.
  - A set event in the same cycle as clr_flags wins: the flag stays 1.
- Direction change (up toggled) takes effect on the next edge. There is no pipeline; latency from input to count is 1 cycle.
- at_hi, at_lo and cfg_err follow count and the limits combinationally.

Decomposition:
- Shared package counter_pkg:
  - MODE_WRAP = 1'b0, MODE_SAT = 1'b1
  - helper constant for the extended width (WIDTH+1)
- One natural sub-module, counter_next_calc, purely combinational:
  - inputs: count, step, up, lo_lim, hi_lim, mode
  - outputs: next_count, ovf_evt, unf_evt
- The top level holds the registers, priority logic, clamp-on-load and flags.

Test Plan:
- Reset and load, WIDTH=4, lo=0, hi=15: rst=1 for 1 cycle -> count=0, flags 0. Then load=1, data=5 -> count=5 at next edge, bnd_pulse=0.
- Wrap up, lo=2, hi=9, mode=0, step=1, count=8, en=1, up=1:
  - count goes 9 (at_hi=1), then 2.
  - bnd_pulse=1 for exactly one cycle, ovf=1 and stays 1.
- Saturate down, lo=2, hi=9, mode=1, step=3, count=4, up=0:
  - count 2, unf=1, bnd_pulse=1.
  - Stays 2 with bnd_pulse=1 each enabled cycle.
  - clr_flags with en=0 -> unf=0.
- Full range and clamp:
  - lo=0, hi=15, wrap, step=3, count=14, up -> count=0, ovf=1.
  - Load data=12 with hi=9 -> count=9.
  - Load data=1 with lo=2 -> count=2.
- Priority and simultaneity:
  - rst+load+en -> count=RST_VAL.
  - load+en with data=7 -> count=7.
  - clr_flags in the same cycle as an overflow -> ovf=1.
- Config error and out-of-range:
  - lo=10, hi=3, en=1, load=1 -> count holds, cfg_err=1.
  - Restore lo=2, hi=6 with count=9, en, up -> count=6 (snap), no flags.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the limited up/down counter
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // One guard bit above the counter width keeps add/subtract free of modular wrap.
   function automatic int ext_w(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/counter_next_calc.sv
// rtl/counter_next_calc.sv - combinational next-count and limit-event evaluation
module counter_next_calc
   import counter_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 2
) (
   input  logic [WIDTH-1:0]  count,
   input  logic [STEP_W-1:0] step,
   input  logic              up,
   input  logic [WIDTH-1:0]  lo_lim,
   input  logic [WIDTH-1:0]  hi_lim,
   input  logic              mode,
   output logic [WIDTH-1:0]  next_count,
   output logic              ovf_evt,
   output logic              unf_evt
);

   localparam int EW = ext_w(WIDTH);

   logic [EW-1:0] step_x;
   logic [EW-1:0] sum;
   logic [EW-1:0] diff;

   assign step_x = EW'(step);
   assign sum    = {1'b0, count} + step_x;
   assign diff   = {1'b0, count} - step_x;

   always_comb begin
      next_count = count;
      ovf_evt    = 1'b0;
      unf_evt    = 1'b0;
      // An out-of-range count (limits moved underneath it) snaps quietly to the nearest limit.
      if (count > hi_lim) begin
         next_count = hi_lim;
      end else if (count < lo_lim) begin
         next_count = lo_lim;
      end else if (step != '0) begin
         if (up) begin
            if (sum <= {1'b0, hi_lim}) begin
               next_count = sum[WIDTH-1:0];
            end else begin
               ovf_evt    = 1'b1;
               next_count = (mode == MODE_SAT) ? hi_lim : lo_lim;
            end
         end else begin
            // diff[WIDTH] set means the subtraction went negative.
            if (!diff[WIDTH] && (diff[WIDTH-1:0] >= lo_lim)) begin
               next_count = diff[WIDTH-1:0];
            end else begin
               unf_evt    = 1'b1;
               next_count = (mode == MODE_SAT) ? lo_lim : hi_lim;
            end
         end
      end
   end

endmodule

// File: rtl/counter_ud_lim.sv
// rtl/counter_ud_lim.sv - parametrised up/down counter with limits, wrap/saturate and sticky flags
module counter_ud_lim
   import counter_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter int               STEP_W  = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up,
   input  logic              load,
   input  logic [WIDTH-1:0]  data,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  lo_lim,
   input  logic [WIDTH-1:0]  hi_lim,
   input  logic              mode,
   input  logic              clr_flags,
   output logic [WIDTH-1:0]  count,
   output logic              bnd_pulse,
   output logic              ovf,
   output logic              unf,
   output logic              at_hi,
   output logic              at_lo,
   output logic              cfg_err
);

   logic [WIDTH-1:0] next_count;
   logic             ovf_evt;
   logic             unf_evt;
   logic [WIDTH-1:0] load_val;

   counter_next_calc #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_next (
      .count      (count),
      .step       (step),
      .up         (up),
      .lo_lim     (lo_lim),
      .hi_lim     (hi_lim),
      .mode       (mode),
      .next_count (next_count),
      .ovf_evt    (ovf_evt),
      .unf_evt    (unf_evt)
   );

   assign cfg_err = (lo_lim > hi_lim);
   assign at_hi   = (count == hi_lim);
   assign at_lo   = (count == lo_lim);

   always_comb begin
      load_val = data;
      if (data > hi_lim) begin
         load_val = hi_lim;
      end else if (data < lo_lim) begin
         load_val = lo_lim;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= RST_VAL;
         bnd_pulse <= 1'b0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else begin
         bnd_pulse <= 1'b0;
         if (clr_flags) begin
            ovf <= 1'b0;
            unf <= 1'b0;
         end
         // Set events are assigned last so they win over a same-cycle clear.
         if (!cfg_err) begin
            if (load) begin
               count <= load_val;
            end else if (en) begin
               count <= next_count;
               if (ovf_evt) begin
                  ovf       <= 1'b1;
                  bnd_pulse <= 1'b1;
               end
               if (unf_evt) begin
                  unf       <= 1'b1;
                  bnd_pulse <= 1'b1;
               end
            end
         end
      end
   end

endmodule
